// File: rtl/rom_word_streamer_pkg.sv
// Shared definitions for rom_word_streamer: default widths and FSM state encodings.
package rom_word_streamer_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned DEPTH_DEF  = 256;
    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned LEN_W_DEF  = 9;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry output skid buffer with valid/ready on both sides; entry 0 is the head.
module stream_skid_buf #(
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
    logic [1:0]       count_q, count_d;
    logic             push, pop;

    assign in_ready_o  = (count_q != 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = ent0_q;
    assign count_o     = count_q;

    assign push = in_valid_i & in_ready_o;
    assign pop  = out_valid_o & out_ready_i;

    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        if (flush_i) begin
            ent0_d  = '0;
            ent1_d  = '0;
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) ent0_d = in_data_i;
                    else                 ent1_d = in_data_i;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    ent0_d  = ent1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        ent0_d = in_data_i;
                    end else begin
                        ent0_d = ent1_q;
                        ent1_d = in_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rom_word_streamer.sv
// Word table with write port, streams a base/len window out over valid/ready.
// Optional transfer checksum enabled by defining STREAM_CHECKSUM_EN.
module rom_word_streamer
    import rom_word_streamer_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              abort_i,
    output logic [DATA_W-1:0] out_o,
    output logic              out_valid_o,
    output logic              out_last_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] checksum_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              in_flight_q, in_last_q;
    logic              is_idle, start_acc, do_abort, pop, rd_ok, rd_issue, last_issue;
    logic              sb_in_ready;
    logic [1:0]        sb_count;

    assign is_idle   = (state_q == StIdle);
    assign start_acc = is_idle & start_i;
    assign do_abort  = ~is_idle & abort_i;
    assign pop       = out_valid_o & out_ready_i;

    // Issue only if buffered + in-flight words, net of this cycle's pop, stays below 2.
    assign rd_ok      = in_flight_q ? ((sb_count == 2'd0) || ((sb_count == 2'd1) && pop))
                                    : (sb_in_ready || pop);
    assign rd_issue   = (state_q == StRun) & ~abort_i & rd_ok;
    assign last_issue = rd_issue & (rem_q == LEN_W'(1));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    addr_d  = base_i;
                    rem_d   = len_i;
                    state_d = (len_i == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (rd_issue) begin
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - LEN_W'(1);
                    if (last_issue) state_d = StDrain;
                end
            end
            StDrain: begin
                if (pop && out_last_o) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
        if (do_abort) state_d = StIdle;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            rem_q       <= '0;
            in_flight_q <= 1'b0;
            in_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            in_flight_q <= rd_issue;
            in_last_q   <= last_issue;
        end
    end

    // Write lands before any read of the same transfer, which starts a cycle later.
    always_ff @(posedge clk_i) begin
        if (is_idle && wr_en_i) mem[wr_addr_i] <= wr_data_i;
        if (rd_issue) rd_data_q <= mem[addr_q];
    end

    stream_skid_buf #(
        .WIDTH(DATA_W + 1)
    ) u_skid (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (do_abort),
        .in_valid_i (in_flight_q & ~do_abort),
        .in_ready_o (sb_in_ready),
        .in_data_i  ({in_last_q, rd_data_q}),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o ({out_last_o, out_o}),
        .count_o    (sb_count)
    );

    assign busy_o = ~is_idle;
    assign done_o = (state_q == StDone);

`ifdef STREAM_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            csum_q <= '0;
        end else if (start_acc) begin
            csum_q <= '0;
        end else if (pop) begin
            csum_q <= csum_q ^ out_o;
        end
    end

    assign checksum_o = csum_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
    assign checksum_o       = '0;
`endif

endmodule

// File: tb/tb_rom_word_streamer.sv
// Directed self-checking bench for rom_word_streamer (checksum expectation follows STREAM_CHECKSUM_EN).
module tb_rom_word_streamer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        start = 1'b0;
    logic [7:0]  base = '0;
    logic [8:0]  len = '0;
    logic        abort = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] out_w, csum;
    logic        out_valid, out_last, busy, done;

    logic [31:0] model [256];
    int checks = 0;
    int errors = 0;

    rom_word_streamer dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .start_i    (start),
        .base_i     (base),
        .len_i      (len),
        .abort_i    (abort),
        .out_o      (out_w),
        .out_valid_o(out_valid),
        .out_last_o (out_last),
        .out_ready_i(ready),
        .busy_o     (busy),
        .done_o     (done),
        .checksum_o (csum)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        model[a] = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic start_xfer(input logic [7:0] b, input logic [8:0] n);
        start = 1'b1; base = b; len = n;
        step();
        start = 1'b0;
    endtask

    // Accept words with ready held high; expects done_o on the sample after the last word.
    task automatic collect(input string tag, input logic [7:0] b, input int n);
        int k = 0;
        logic [7:0] a;
        ready = 1'b1;
        for (int c = 0; c < 40 && k < n; c++) begin
            if (out_valid) begin
                a = b + 8'(k);
                chk({tag, "_word"}, out_w, model[a]);
                chk({tag, "_last"}, 32'(out_last), 32'(k == n - 1));
                k++;
            end
            step();
        end
        chk({tag, "_count"}, k, n);
        chk({tag, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        logic [31:0] held;
        logic        held_v;
        int          idx;

        // Reset values
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_out", out_w, 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_csum", csum, 32'd0);
        step();
        rst = 1'b0;
        step();

        for (int k = 0; k < 256; k++) wr(8'(k), 32'(k) * 32'h0101_0101);

        // Basic transfer, exact cycle timing
        ready = 1'b1;
        start_xfer(8'h10, 9'd4);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_v0", 32'(out_valid), 32'd0);
        step();
        chk("t1_v1", 32'(out_valid), 32'd0);
        step();
        chk("t1_v2", 32'(out_valid), 32'd1);
        chk("t1_w0", out_w, 32'h1010_1010);
        chk("t1_l0", 32'(out_last), 32'd0);
        step();
        chk("t1_w1", out_w, 32'h1111_1111);
        step();
        chk("t1_w2", out_w, 32'h1212_1212);
        step();
        chk("t1_w3", out_w, 32'h1313_1313);
        chk("t1_l3", 32'(out_last), 32'd1);
        step();
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_vend", 32'(out_valid), 32'd0);
        step();
        chk("t1_done_pulse", 32'(done), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);

        // Address wrap-around FE, FF, 00, 01
        start_xfer(8'hFE, 9'd4);
        collect("wrap", 8'hFE, 4);
        chk("wrap_w3", model[8'h01], 32'h0101_0101);
        step();

        // Backpressure 1,0,0,1,...
        start_xfer(8'h20, 9'd8);
        idx = 0;
        held = '0;
        held_v = 1'b0;
        for (int c = 0; c < 80 && idx < 8; c++) begin
            ready = (c % 4 == 0) || (c % 4 == 3);
            if (held_v) begin
                chk("bp_hold_v", 32'(out_valid), 32'd1);
                chk("bp_hold_w", out_w, held);
            end
            held_v = 1'b0;
            if (out_valid) begin
                if (ready) begin
                    chk("bp_word", out_w, {4{8'h20 + 8'(idx)}});
                    chk("bp_last", 32'(out_last), 32'(idx == 7));
                    idx++;
                end else begin
                    held   = out_w;
                    held_v = 1'b1;
                end
            end
            step();
        end
        chk("bp_count", idx, 8);
        chk("bp_done", 32'(done), 32'd1);
        ready = 1'b1;
        step();

        // Abort two cycles after start while stalled
        ready = 1'b0;
        start_xfer(8'h30, 9'd8);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_valid", 32'(out_valid), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);
        for (int c = 0; c < 3; c++) begin
            chk("ab_nodone", 32'(done), 32'd0);
            chk("ab_novalid", 32'(out_valid), 32'd0);
            step();
        end
        start_xfer(8'h40, 9'd2);
        collect("ab_restart", 8'h40, 2);
        step();

        // Zero-length transfer
        start_xfer(8'h00, 9'd0);
        chk("z_done", 32'(done), 32'd1);
        chk("z_valid", 32'(out_valid), 32'd0);
        step();
        chk("z_done_pulse", 32'(done), 32'd0);
        chk("z_idle", 32'(busy), 32'd0);
        chk("z_valid2", 32'(out_valid), 32'd0);

        // Start and write during RUN are ignored
        ready = 1'b0;
        start_xfer(8'h50, 9'd4);
        wr_en = 1'b1; wr_addr = 8'h51; wr_data = 32'hDEAD_BEEF;
        start = 1'b1; base = 8'h00; len = 9'd1;
        step();
        wr_en = 1'b0; start = 1'b0;
        collect("ign", 8'h50, 4);
        step();
        chk("ign_idle", 32'(busy), 32'd0);
        step();
        chk("ign_idle2", 32'(busy), 32'd0);
        start_xfer(8'h51, 9'd1);
        collect("ign_tab", 8'h51, 1);
        step();

        // Checksum over 1,2,4,8
        wr(8'h60, 32'd1);
        wr(8'h61, 32'd2);
        wr(8'h62, 32'd4);
        wr(8'h63, 32'd8);
        start_xfer(8'h60, 9'd4);
        collect("cs", 8'h60, 4);
`ifdef STREAM_CHECKSUM_EN
        chk("cs_value", csum, 32'h0000_000F);
`else
        chk("cs_value", csum, 32'h0000_0000);
`endif
        step();

        // Reset mid-transfer
        start_xfer(8'h70, 9'd8);
        step();
        step();
        rst = 1'b1;
        #1;
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_done", 32'(done), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("mr_idle", 32'(busy), 32'd0);
        start_xfer(8'h72, 9'd2);
        collect("mr_after", 8'h72, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
